// File: rtl/sample_window_acc_pkg.sv
// rtl/sample_window_acc_pkg.sv - state encodings and shared defaults for the window accumulator
package sample_window_acc_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    localparam int DEFAULT_DATA_W = 5;

endpackage

// File: rtl/sample_window_acc.sv
// rtl/sample_window_acc.sv - collects a window of samples and emits sum/min/max/count
module sample_window_acc
    import sample_window_acc_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int WINDOW = 16,
    parameter int CNT_W  = $clog2(WINDOW + 1),
    parameter int SUM_W  = DATA_W + $clog2(WINDOW + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [SUM_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

    state_e state_q, state_d;

    logic [SUM_W-1:0]  acc_sum_q, acc_sum_d, out_sum_q, out_sum_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d, out_cnt_q, out_cnt_d;
    logic [DATA_W-1:0] acc_min_q, acc_min_d, out_min_q, out_min_d;
    logic [DATA_W-1:0] acc_max_q, acc_max_d, out_max_q, out_max_d;

    logic              accept;
    logic              close;
    logic [SUM_W-1:0]  upd_sum;
    logic [CNT_W-1:0]  upd_cnt;
    logic [DATA_W-1:0] upd_min;
    logic [DATA_W-1:0] upd_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACCUM;
            acc_sum_q <= '0;
            acc_cnt_q <= '0;
            acc_min_q <= '1;
            acc_max_q <= '0;
            out_sum_q <= '0;
            out_cnt_q <= '0;
            out_min_q <= '0;
            out_max_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_sum_q <= acc_sum_d;
            acc_cnt_q <= acc_cnt_d;
            acc_min_q <= acc_min_d;
            acc_max_q <= acc_max_d;
            out_sum_q <= out_sum_d;
            out_cnt_q <= out_cnt_d;
            out_min_q <= out_min_d;
            out_max_q <= out_max_d;
        end
    end

    // The closing sample is folded in before the result is captured.
    always_comb begin
        accept  = in_valid & in_ready;
        upd_sum = acc_sum_q;
        upd_cnt = acc_cnt_q;
        upd_min = acc_min_q;
        upd_max = acc_max_q;
        if (accept) begin
            upd_sum = acc_sum_q + SUM_W'(in_data);
            upd_cnt = acc_cnt_q + CNT_W'(1);
            upd_min = (in_data < acc_min_q) ? in_data : acc_min_q;
            upd_max = (in_data > acc_max_q) ? in_data : acc_max_q;
        end

        close = (state_q == ST_ACCUM) &&
                ((accept && (acc_cnt_q == CNT_LAST)) ||
                 (flush && ((acc_cnt_q != '0) || accept)));

        acc_sum_d = upd_sum;
        acc_cnt_d = upd_cnt;
        acc_min_d = upd_min;
        acc_max_d = upd_max;
        out_sum_d = out_sum_q;
        out_cnt_d = out_cnt_q;
        out_min_d = out_min_q;
        out_max_d = out_max_q;
        if (close) begin
            out_sum_d = upd_sum;
            out_cnt_d = upd_cnt;
            out_min_d = upd_min;
            out_max_d = upd_max;
            acc_sum_d = '0;
            acc_cnt_d = '0;
            acc_min_d = '1;
            acc_max_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (close)     state_d = ST_HOLD;
            ST_HOLD:  if (out_ready) state_d = ST_ACCUM;
            default:                 state_d = ST_ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_ACCUM) && !rst;
        out_valid = (state_q == ST_HOLD);
        out_sum   = out_sum_q;
        out_cnt   = out_cnt_q;
        out_min   = out_min_q;
        out_max   = out_max_q;
    end

endmodule
